nzcv_cond_unit: RTL and testbench
=================================

Name: nzcv_cond_unit

Overview:
- Downstream consumer of the ALU's flag outputs: holds the architectural NZCV register and evaluates LEGv8 B.cond conditions against it.
- Flags arrive from the EX/MEM pipeline register, i.e. the ALU's `CPSR_flags`/`write_flags` registered one stage.
- The B.cond under evaluation sits in EX.
- Produces a registered branch decision for the MEM stage, plus a saturating taken-branch counter.

Parameters:
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flags_i  in  4  flags from the EX/MEM register: [3]=Z, [2]=N, [1]=C, [0]=V (same bit order as the ALU's `CPSR_flags`).
- write_flags_i  in  1  flag-setting instruction in MEM; load `flags_i` into NZCV.
- bcond_i  in  1  the instruction in EX is a B.cond.
- cond_i  in  4  condition field of that B.cond.
- stall_i  in  1  EX is frozen this cycle.
- flush_i  in  1  kill the EX-stage instruction.
- nzcv_o  out  4  architectural flags register, same bit order.
- flags_valid_o  out  1  at least one flag write has occurred since reset.
- branch_valid_o  out  1  registered: a B.cond was evaluated last cycle.
- branch_taken_o  out  1  registered: that B.cond is taken.
- undef_flags_o  out  1  sticky: a B.cond was evaluated while flags_valid was 0.
- taken_cnt_o  out  CNT_W  saturating count of taken B.cond decisions.

Behaviour:
- Reset (sync, highest priority), all outputs to zero: nzcv_o=0000, flags_valid_o=0, branch_valid_o=0, branch_taken_o=0, undef_flags_o=0, taken_cnt_o=0.
- Flag state (2 states):
  - FLAGS_EMPTY → FLAGS_VALID on the first accepted write; leaves FLAGS_VALID only on reset.
  - flags_valid_o=1 in FLAGS_VALID.
- Flag write:
  - When write_flags_i=1: nzcv_q <= flags_i next edge.
  - Independent of stall_i and flush_i, because they act on EX and the writer is older, in MEM.
- Effective flags for evaluation (eff): nzcv_q (registered only) unless NZCV_BYPASS_EN is defined; see Optional Feature.
- Condition decode (cond_i → taken), with Z,N,C,V taken from eff:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 HS: C
  - 0011 LO: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !(C&!Z)
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: !(!Z&(N==V))
  - 1110 AL: 1
  - 1111 NV: 1
- Undefined flags: if the effective flags are still in FLAGS_EMPTY when a B.cond is evaluated:
  - taken = 1 only for AL and NV, 0 for every other condition.
  - undef_flags_o is set and stays set until reset.
- Decision register, 1-cycle latency. Per edge, priority reset > flush > stall:
  - flush_i=1: branch_valid_o <= 0, branch_taken_o <= 0.
  - else stall_i=1: both outputs hold their current value; no evaluation, no count, no undef set.
  - else: branch_valid_o <= bcond_i; branch_taken_o <= bcond_i & taken.
  - bcond_i=0: branch_valid_o <= 0, branch_taken_o <= 0.
- Counter:
  - taken_cnt_o increments on every edge that loads branch_taken_o <= 1.
  - Saturates at all-ones (2^CNT_W − 1); never wraps.
  - Cleared only by reset.
- Simultaneous events:
  - write_flags_i together with an evaluating bcond_i: the flags register updates, and evaluation uses eff.
  - flush_i together with write_flags_i: the write still completes.
  - Reset asserted mid-stall or mid-flush: reset wins, and all state is zero next cycle.

Optional Feature:
- Macro: NZCV_BYPASS_EN.
- Defined:
  - When write_flags_i=1, eff = flags_i and eff counts as FLAGS_VALID in the same cycle.
  - A B.cond directly behind a flag-setter resolves without a stall.
- Undefined:
  - eff = nzcv_q always.
  - Hazard logic upstream must stall the B.cond one cycle.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then bcond_i=1, cond=0000 (EQ), no writes → next cycle: branch_valid_o=1, branch_taken_o=0, undef_flags_o=1, taken_cnt_o=0.
- write flags_i=1000 (Z=1), then next cycle bcond with cond=0000 → branch_taken_o=1 one cycle later, taken_cnt_o=1; cond=0001 in the following cycle → branch_taken_o=0.
- flags_i=0101 (N=1, V=1), cond=1010 (GE) → taken=1; cond=1011 (LT) → taken=0; cond=1100 (GT) → taken=1.
- Same cycle: write_flags_i with flags_i=0010 (C=1) and bcond with cond=0010 (HS), nzcv_q=0000:
  - With NZCV_BYPASS_EN: taken=1.
  - Without it: taken=0.
  - nzcv_o=0010 afterwards in both builds.
- Branch outputs registered at valid=1, taken=1; then stall_i=1 for 3 cycles with bcond cond=1110 (AL) → outputs held at 1/1 and taken_cnt_o unchanged; then flush_i=1 together with stall_i → outputs 0/0.
- CNT_W=2: 5 consecutive AL branches → taken_cnt_o goes 1, 2, 3, 3, 3; then reset → 0, and nzcv_o=0000, flags_valid_o=0.

Source files
------------

// File: rtl/nzcv_cond_unit.sv
// nzcv_cond_unit: architectural NZCV register + LEGv8 B.cond evaluator.
// Flags come from EX/MEM (flags_i order {Z,N,C,V}); the B.cond sits in EX.
// Ports: clk, reset (sync, active-high), flags_i, write_flags_i, bcond_i,
//   cond_i, stall_i, flush_i -> nzcv_o, flags_valid_o, branch_valid_o,
//   branch_taken_o, undef_flags_o, taken_cnt_o (saturating, CNT_W bits).
// Optional macro NZCV_BYPASS_EN: forward flags_i to the evaluator in the
//   same cycle as the write (default build evaluates registered flags).
module nzcv_cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       flags_i,
  input  logic             write_flags_i,
  input  logic             bcond_i,
  input  logic [3:0]       cond_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [3:0]       nzcv_o,
  output logic             flags_valid_o,
  output logic             branch_valid_o,
  output logic             branch_taken_o,
  output logic             undef_flags_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [0:0] FLAGS_EMPTY = 1'b0;
  localparam logic [0:0] FLAGS_VALID = 1'b1;

  logic [0:0]       r_state;
  logic [3:0]       r_nzcv;
  logic             r_bv;
  logic             r_bt;
  logic             r_undef;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0] w_eff;
  logic       w_eff_valid;
  logic       w_z, w_n, w_c, w_v;
  logic       w_pred;
  logic       w_taken;
  logic       w_eval;
  logic       w_cnt_max;

`ifdef NZCV_BYPASS_EN
  // The writer in MEM forwards straight into the EX evaluation.
  assign w_eff       = write_flags_i ? flags_i : r_nzcv;
  assign w_eff_valid = write_flags_i | (r_state == FLAGS_VALID);
`else
  assign w_eff       = r_nzcv;
  assign w_eff_valid = (r_state == FLAGS_VALID);
`endif

  assign w_z = w_eff[3];
  assign w_n = w_eff[2];
  assign w_c = w_eff[1];
  assign w_v = w_eff[0];

  always_comb begin
    w_pred = 1'b0;
    unique case (cond_i)
      4'b0000: w_pred = w_z;
      4'b0001: w_pred = !w_z;
      4'b0010: w_pred = w_c;
      4'b0011: w_pred = !w_c;
      4'b0100: w_pred = w_n;
      4'b0101: w_pred = !w_n;
      4'b0110: w_pred = w_v;
      4'b0111: w_pred = !w_v;
      4'b1000: w_pred = w_c & !w_z;
      4'b1001: w_pred = !(w_c & !w_z);
      4'b1010: w_pred = (w_n == w_v);
      4'b1011: w_pred = (w_n != w_v);
      4'b1100: w_pred = !w_z & (w_n == w_v);
      4'b1101: w_pred = !(!w_z & (w_n == w_v));
      4'b1110: w_pred = 1'b1;
      4'b1111: w_pred = 1'b1;
      default: w_pred = 1'b0;
    endcase
  end

  // With no flags yet, only the unconditional encodings may be taken.
  assign w_taken   = w_eff_valid ? w_pred : (cond_i[3:1] == 3'b111);
  assign w_eval    = bcond_i & !flush_i & !stall_i;
  assign w_cnt_max = &r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FLAGS_EMPTY;
      r_nzcv  <= 4'b0000;
      r_bv    <= 1'b0;
      r_bt    <= 1'b0;
      r_undef <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // The writer is in MEM, so EX stall/flush never blocks it.
      if (write_flags_i) begin
        r_nzcv  <= flags_i;
        r_state <= FLAGS_VALID;
      end
      if (flush_i) begin
        r_bv <= 1'b0;
        r_bt <= 1'b0;
      end else if (!stall_i) begin
        r_bv <= bcond_i;
        r_bt <= bcond_i & w_taken;
      end
      if (w_eval && !w_eff_valid)
        r_undef <= 1'b1;
      if (w_eval && w_taken && !w_cnt_max)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign nzcv_o         = r_nzcv;
  assign flags_valid_o  = (r_state == FLAGS_VALID);
  assign branch_valid_o = r_bv;
  assign branch_taken_o = r_bt;
  assign undef_flags_o  = r_undef;
  assign taken_cnt_o    = r_cnt;

endmodule

// File: tb/tb_nzcv_cond_unit.sv
// tb_nzcv_cond_unit: directed + randomized bench for nzcv_cond_unit.
// Reference model computes decisions from the condition table directly.
module tb_nzcv_cond_unit;

  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    flags_i;
  logic          write_flags_i;
  logic          bcond_i;
  logic [3:0]    cond_i;
  logic          stall_i;
  logic          flush_i;
  logic [3:0]    nzcv_o;
  logic          flags_valid_o;
  logic          branch_valid_o;
  logic          branch_taken_o;
  logic          undef_flags_o;
  logic [CW-1:0] taken_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [3:0] m_nzcv;
  bit m_fv, m_bv, m_bt, m_undef;
  int m_cnt;

  nzcv_cond_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flags_i(flags_i),
    .write_flags_i(write_flags_i), .bcond_i(bcond_i), .cond_i(cond_i),
    .stall_i(stall_i), .flush_i(flush_i), .nzcv_o(nzcv_o),
    .flags_valid_o(flags_valid_o), .branch_valid_o(branch_valid_o),
    .branch_taken_o(branch_taken_o), .undef_flags_o(undef_flags_o),
    .taken_cnt_o(taken_cnt_o)
  );

  always #5 clk = ~clk;

`ifdef NZCV_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Pairs of conditions share a predicate; odd encodings negate it.
  function automatic bit ref_taken(logic [3:0] c, logic [3:0] f, bit v);
    bit z, n, cy, ov, p;
    z = f[3]; n = f[2]; cy = f[1]; ov = f[0];
    if (c[3:1] == 3'b111) return 1'b1;
    if (!v) return 1'b0;
    case (c[3:1])
      3'd0: p = z;
      3'd1: p = cy;
      3'd2: p = n;
      3'd3: p = ov;
      3'd4: p = cy && !z;
      3'd5: p = (n == ov);
      3'd6: p = !z && (n == ov);
      default: p = 1'b1;
    endcase
    return p ^ c[0];
  endfunction

  task automatic idle();
    reset = 0; flags_i = 0; write_flags_i = 0; bcond_i = 0;
    cond_i = 0; stall_i = 0; flush_i = 0;
  endtask

  // Advance one clock, updating the model from the applied inputs.
  task automatic cyc();
    logic [3:0] eff;
    bit effv, tk, ev;
    if (reset) begin
      m_nzcv = 0; m_fv = 0; m_bv = 0; m_bt = 0; m_undef = 0; m_cnt = 0;
    end else begin
      eff  = (BYP && write_flags_i) ? flags_i : m_nzcv;
      effv = m_fv || (BYP && write_flags_i);
      tk   = ref_taken(cond_i, eff, effv);
      ev   = bcond_i && !stall_i && !flush_i;
      if (flush_i) begin
        m_bv = 0; m_bt = 0;
      end else if (!stall_i) begin
        m_bv = bcond_i; m_bt = bcond_i && tk;
      end
      if (ev && !effv) m_undef = 1;
      if (ev && tk && m_cnt < CMAX) m_cnt++;
      if (write_flags_i) begin
        m_nzcv = flags_i; m_fv = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; cyc(); idle();
    n_tests++;
    if ({nzcv_o, flags_valid_o, branch_valid_o, branch_taken_o,
         undef_flags_o, taken_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset: got nzcv=%b fv=%b bv=%b bt=%b u=%b cnt=%0d",
        nzcv_o, flags_valid_o, branch_valid_o, branch_taken_o,
        undef_flags_o, taken_cnt_o);
    end
  endtask

  task automatic test_undef();
    idle(); bcond_i = 1; cond_i = 4'b0000; cyc(); idle();
    n_tests++;
    if ({branch_valid_o, branch_taken_o, undef_flags_o} !== 3'b101 ||
        taken_cnt_o !== 0) begin
      n_fail++;
      $display("FAIL undef_eq: got bv/bt/u=%b%b%b cnt=%0d want 101 cnt=0",
        branch_valid_o, branch_taken_o, undef_flags_o, taken_cnt_o);
    end
  endtask

  task automatic test_eq_ne();
    idle(); write_flags_i = 1; flags_i = 4'b1000; cyc(); idle();
    bcond_i = 1; cond_i = 4'b0000; cyc();
    n_tests++;
    if (branch_taken_o !== 1'b1 || taken_cnt_o !== 1) begin
      n_fail++;
      $display("FAIL eq_taken: got bt=%b cnt=%0d want bt=1 cnt=1",
        branch_taken_o, taken_cnt_o);
    end
    cond_i = 4'b0001; cyc(); idle();
    n_tests++;
    if (branch_taken_o !== 1'b0 || branch_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ne_not_taken: got bv=%b bt=%b want 1/0",
        branch_valid_o, branch_taken_o);
    end
  endtask

  task automatic test_signed();
    logic [3:0] cs [3];
    bit exp [3];
    cs[0] = 4'b1010; cs[1] = 4'b1011; cs[2] = 4'b1100;
    exp[0] = 1; exp[1] = 0; exp[2] = 1;
    idle(); write_flags_i = 1; flags_i = 4'b0101; cyc(); idle();
    for (int i = 0; i < 3; i++) begin
      bcond_i = 1; cond_i = cs[i]; cyc();
      n_tests++;
      if (branch_taken_o !== exp[i] || taken_cnt_o !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL signed_cond %b: got bt=%b cnt=%0d want bt=%b cnt=%0d",
          cs[i], branch_taken_o, taken_cnt_o, exp[i], m_cnt);
      end
    end
    idle();
  endtask

  task automatic test_same_cycle();
    bit want;
    want = BYP;
    idle(); reset = 1; cyc(); idle();
    write_flags_i = 1; flags_i = 4'b0000; cyc(); idle();
    write_flags_i = 1; flags_i = 4'b0010; bcond_i = 1; cond_i = 4'b0010;
    cyc(); idle();
    n_tests++;
    if (branch_taken_o !== want || nzcv_o !== 4'b0010 ||
        branch_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_hs: got bv=%b bt=%b nzcv=%b want 1/%b/0010",
        branch_valid_o, branch_taken_o, nzcv_o, want);
    end
  endtask

  task automatic test_stall_flush();
    logic [CW-1:0] c0;
    idle(); reset = 1; cyc(); idle();
    bcond_i = 1; cond_i = 4'b1110; cyc();
    c0 = taken_cnt_o;
    n_tests++;
    if ({branch_valid_o, branch_taken_o} !== 2'b11 || c0 !== 1) begin
      n_fail++;
      $display("FAIL al_before_stall: got %b%b cnt=%0d want 11 cnt=1",
        branch_valid_o, branch_taken_o, c0);
    end
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if ({branch_valid_o, branch_taken_o} !== 2'b11 || taken_cnt_o !== 1) begin
        n_fail++;
        $display("FAIL stall_hold %0d: got %b%b cnt=%0d want 11 cnt=1",
          i, branch_valid_o, branch_taken_o, taken_cnt_o);
      end
    end
    flush_i = 1; cyc(); idle();
    n_tests++;
    if ({branch_valid_o, branch_taken_o} !== 2'b00 || taken_cnt_o !== 1) begin
      n_fail++;
      $display("FAIL flush_stall: got %b%b cnt=%0d want 00 cnt=1",
        branch_valid_o, branch_taken_o, taken_cnt_o);
    end
  endtask

  task automatic test_saturation();
    int exp [5];
    exp[0] = 1; exp[1] = 2; exp[2] = 3; exp[3] = 3; exp[4] = 3;
    idle(); reset = 1; cyc(); idle();
    write_flags_i = 1; flags_i = 4'b1111; cyc(); idle();
    for (int i = 0; i < 5; i++) begin
      bcond_i = 1; cond_i = 4'b1110; cyc();
      n_tests++;
      if (taken_cnt_o !== CW'(exp[i])) begin
        n_fail++;
        $display("FAIL sat_cnt %0d: got %0d want %0d", i, taken_cnt_o, exp[i]);
      end
    end
    idle(); reset = 1; stall_i = 1; flush_i = 1; cyc(); idle();
    n_tests++;
    if (taken_cnt_o !== 0 || nzcv_o !== 4'b0000 || flags_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_reset: got cnt=%0d nzcv=%b fv=%b want 0/0000/0",
        taken_cnt_o, nzcv_o, flags_valid_o);
    end
  endtask

  task automatic test_random();
    logic [4+CW+3:0] got, want;
    idle(); reset = 1; cyc(); idle();
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 29) == 0);
      flags_i       = 4'($urandom);
      write_flags_i = ($urandom_range(0, 3) == 0);
      bcond_i       = ($urandom_range(0, 2) != 0);
      cond_i        = 4'($urandom);
      stall_i       = ($urandom_range(0, 5) == 0);
      flush_i       = ($urandom_range(0, 7) == 0);
      cyc();
      got  = {nzcv_o, flags_valid_o, branch_valid_o, branch_taken_o,
              undef_flags_o, taken_cnt_o};
      want = {m_nzcv, m_fv, m_bv, m_bt, m_undef, CW'(m_cnt)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", i, got, want);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    m_nzcv = 0; m_fv = 0; m_bv = 0; m_bt = 0; m_undef = 0; m_cnt = 0;
    @(posedge clk); #1;
    test_reset();
    test_undef();
    test_eq_ne();
    test_signed();
    test_same_cycle();
    test_stall_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
